// File: rtl/dm_lsu_pkg.sv
// Shared definitions for the data-memory load/store unit: access-control
// encodings, FSM state encoding and size/sign decode helpers.
package dm_lsu_pkg;

   localparam logic [2:0] dm_word              = 3'd0;
   localparam logic [2:0] dm_halfword          = 3'd1;
   localparam logic [2:0] dm_halfword_unsigned = 3'd2;
   localparam logic [2:0] dm_byte              = 3'd3;
   localparam logic [2:0] dm_byte_unsigned     = 3'd4;
   localparam logic [2:0] dm_dword             = 3'd5;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_BEAT0,
      ST_BEAT1,
      ST_RESP,
      ST_ERR
   } lsu_state_t;

   // Access size in bytes; 0 marks an encoding with no defined size.
   function automatic logic [3:0] ctrlSize(input logic [2:0] ctrl);
      case (ctrl)
         dm_byte, dm_byte_unsigned:         ctrlSize = 4'd1;
         dm_halfword, dm_halfword_unsigned: ctrlSize = 4'd2;
         dm_word:                           ctrlSize = 4'd4;
         dm_dword:                          ctrlSize = 4'd8;
         default:                           ctrlSize = 4'd0;
      endcase
   endfunction

   function automatic logic ctrlSigned(input logic [2:0] ctrl);
      ctrlSigned = (ctrl == dm_byte) || (ctrl == dm_halfword) || (ctrl == dm_word);
   endfunction

endpackage

// File: rtl/dm_lane_align.sv
// Byte-lane steering for one access: byte enables and positioned write data
// for the current beat, plus merge/shift/extend of the gathered read lanes.
module dm_lane_align #(
   parameter  int DATA_W = 32,
   localparam int BYTES  = DATA_W / 8,
   localparam int OFF_W  = $clog2(BYTES)
) (
   input  logic [OFF_W-1:0]    i_off,
   input  logic [3:0]          i_size,
   input  logic                i_beat1,
   input  logic                i_signed,
   input  logic [DATA_W-1:0]   i_wdata,
   input  logic [2*DATA_W-1:0] i_rdata,
   output logic [BYTES-1:0]    o_be,
   output logic [DATA_W-1:0]   o_wdata,
   output logic [DATA_W-1:0]   o_rdata
);

   logic [2*BYTES-1:0]  w_mask;
   logic [2*BYTES-1:0]  w_beFull;
   logic [2*DATA_W-1:0] w_wFull;
   logic [DATA_W-1:0]   w_rLow;
   logic                w_signBit;

   always_comb begin
      w_mask = '0;
      for (int i = 0; i < 2 * BYTES; i++) begin
         w_mask[i] = (i < int'(i_size));
      end
   end

   // Double-width views: the low half is beat 0, the spill-over is beat 1.
   assign w_beFull = w_mask << i_off;
   assign w_wFull  = {{DATA_W{1'b0}}, i_wdata} << {i_off, 3'b000};
   assign o_be     = i_beat1 ? w_beFull[2*BYTES-1:BYTES] : w_beFull[BYTES-1:0];
   assign o_wdata  = i_beat1 ? w_wFull[2*DATA_W-1:DATA_W] : w_wFull[DATA_W-1:0];

   assign w_rLow = DATA_W'(i_rdata >> {i_off, 3'b000});

   always_comb begin
      case (i_size)
         4'd1:    w_signBit = w_rLow[7];
         4'd2:    w_signBit = w_rLow[15];
         4'd4:    w_signBit = w_rLow[31];
         default: w_signBit = 1'b0;
      endcase
   end

   always_comb begin
      o_rdata = '0;
      for (int i = 0; i < DATA_W; i++) begin
         o_rdata[i] = (i < 8 * int'(i_size)) ? w_rLow[i] : (i_signed & w_signBit);
      end
   end

endmodule

// File: rtl/dm_lsu.sv
// Sequential load/store unit: one request at a time, word-aligned memory
// beats with byte enables, optional two-beat split of boundary-crossing accesses.
module dm_lsu
   import dm_lsu_pkg::*;
#(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 32,
   parameter int SPLIT_EN = 1
) (
   input  logic                clk,
   input  logic                rstn,
   input  logic                req_valid,
   output logic                req_ready,
   input  logic                req_we,
   input  logic [ADDR_W-1:0]   req_addr,
   input  logic [2:0]          req_ctrl,
   input  logic [DATA_W-1:0]   req_wdata,
   output logic                resp_valid,
   output logic [DATA_W-1:0]   resp_rdata,
   output logic                misalign_err,
   output logic                mem_req,
   output logic                mem_we,
   output logic [ADDR_W-1:0]   mem_addr,
   output logic [DATA_W/8-1:0] mem_be,
   output logic [DATA_W-1:0]   mem_wdata,
   input  logic                mem_ack,
   input  logic [DATA_W-1:0]   mem_rdata
);

   localparam int BYTES  = DATA_W / 8;
   localparam int OFF_W  = $clog2(BYTES);
   localparam int WORD_W = ADDR_W - OFF_W;

   lsu_state_t          r_state;
   lsu_state_t          w_next;
   logic                r_we;
   logic [WORD_W-1:0]   r_word;
   logic [OFF_W-1:0]    r_off;
   logic [3:0]          r_size;
   logic                r_signed;
   logic                r_cross;
   logic [DATA_W-1:0]   r_wdata;
   logic [2*DATA_W-1:0] r_rdata;

   logic [OFF_W-1:0]    w_reqOff;
   logic [3:0]          w_reqSize;
   logic [4:0]          w_end;
   logic                w_illegal;
   logic                w_cross;
   logic                w_reject;
   logic                w_accept;
   logic [WORD_W-1:0]   w_word1;
   logic [BYTES-1:0]    w_be;
   logic [DATA_W-1:0]   w_wdata;
   logic [DATA_W-1:0]   w_rdata;

   assign w_reqOff  = req_addr[OFF_W-1:0];
   assign w_reqSize = ctrlSize(req_ctrl);
   assign w_end     = 5'(w_reqOff) + 5'(w_reqSize);
   assign w_illegal = (w_reqSize == 4'd0) || (w_reqSize > 4'(BYTES));
   assign w_cross   = (w_end > 5'(BYTES));
   assign w_reject  = w_illegal || (w_cross && (SPLIT_EN == 0));
   assign w_accept  = req_valid && (r_state == ST_IDLE);
   assign w_word1   = r_word + WORD_W'(1);

   dm_lane_align #(
      .DATA_W (DATA_W)
   ) u_align (
      .i_off    (r_off),
      .i_size   (r_size),
      .i_beat1  (r_state == ST_BEAT1),
      .i_signed (r_signed),
      .i_wdata  (r_wdata),
      .i_rdata  (r_rdata),
      .o_be     (w_be),
      .o_wdata  (w_wdata),
      .o_rdata  (w_rdata)
   );

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Request fields are captured at acceptance; read lanes fill in per beat ack.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_we     <= 1'b0;
         r_word   <= '0;
         r_off    <= '0;
         r_size   <= '0;
         r_signed <= 1'b0;
         r_cross  <= 1'b0;
         r_wdata  <= '0;
         r_rdata  <= '0;
      end else if (w_accept) begin
         r_we     <= req_we;
         r_word   <= req_addr[ADDR_W-1:OFF_W];
         r_off    <= w_reqOff;
         r_size   <= w_reqSize;
         r_signed <= ctrlSigned(req_ctrl);
         r_cross  <= w_cross;
         r_wdata  <= req_wdata;
         r_rdata  <= '0;
      end else if (mem_ack && !r_we) begin
         if (r_state == ST_BEAT0) begin
            r_rdata[DATA_W-1:0] <= mem_rdata;
         end else if (r_state == ST_BEAT1) begin
            r_rdata[2*DATA_W-1:DATA_W] <= mem_rdata;
         end
      end
   end

   always_comb begin
      w_next       = r_state;
      req_ready    = 1'b0;
      resp_valid   = 1'b0;
      resp_rdata   = '0;
      misalign_err = 1'b0;
      mem_req      = 1'b0;
      mem_we       = 1'b0;
      mem_addr     = '0;
      mem_be       = '0;
      mem_wdata    = '0;
      case (r_state)
         ST_IDLE: begin
            req_ready = 1'b1;
            if (req_valid) begin
               w_next = w_reject ? ST_ERR : ST_BEAT0;
            end
         end
         ST_BEAT0: begin
            mem_req   = 1'b1;
            mem_we    = r_we;
            mem_addr  = {r_word, {OFF_W{1'b0}}};
            mem_be    = w_be;
            mem_wdata = r_we ? w_wdata : '0;
            if (mem_ack) begin
               w_next = r_cross ? ST_BEAT1 : ST_RESP;
            end
         end
         ST_BEAT1: begin
            mem_req   = 1'b1;
            mem_we    = r_we;
            mem_addr  = {w_word1, {OFF_W{1'b0}}};
            mem_be    = w_be;
            mem_wdata = r_we ? w_wdata : '0;
            if (mem_ack) begin
               w_next = ST_RESP;
            end
         end
         ST_RESP: begin
            resp_valid = 1'b1;
            resp_rdata = r_we ? '0 : w_rdata;
            w_next     = ST_IDLE;
         end
         ST_ERR: begin
            resp_valid   = 1'b1;
            misalign_err = 1'b1;
            w_next       = ST_IDLE;
         end
         default: w_next = ST_IDLE;
      endcase
   end

endmodule
